// File: rtl/load_store_unit_if.sv
// Bus bundle between the core execute stage, the load/store unit and memory_controller.
// master = core + memory side driving into the LSU, slave = the LSU itself.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_write_enable, mem_data_in
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_write_enable, mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end for memory_controller: alignment/region checks, one access cycle, load extension.
// Define LSU_STATS_EN to build the stat_loads/stat_stores/stat_faults counters; otherwise they read 0.
module load_store_unit #(
    parameter logic [3:0] REGION_ROM = 4'h0,
    parameter logic [3:0] REGION_RAM = 4'h1,
    parameter logic [2:0] IO_PREFIX  = 3'b001
) (
    input  logic        clk,
    input  logic        rst_n,
    load_store_unit_if.slave bus,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_faults
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic        rsp_done_s;
    logic [1:0]  fault_s;
    logic        we_r;
    logic        uns_r;
    logic        rom_r;
    logic [1:0]  size_r;
    logic [1:0]  off_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic [1:0]  rsp_err_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_in_r;
    logic [2:0]  mem_we_r;
    logic [31:0] load_raw_s;
    logic [31:0] load_ext_s;

    // Fault priority: misaligned, then unmapped, then store into ROM.
    function automatic logic [1:0] fault_code(input logic [31:0] addr,
                                              input logic [1:0]  size,
                                              input logic        we);
        logic misaligned;
        logic unmapped;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        unmapped = (addr[31:28] != REGION_ROM) && (addr[31:28] != REGION_RAM) &&
                   (addr[31:29] != IO_PREFIX);
        if (misaligned) begin
            fault_code = 2'd1;
        end else if (unmapped) begin
            fault_code = 2'd2;
        end else if (we && (addr[31:28] == REGION_ROM)) begin
            fault_code = 2'd3;
        end else begin
            fault_code = 2'd0;
        end
    endfunction

    function automatic logic [2:0] size_strobe(input logic [1:0] size);
        case (size)
            2'd0:    size_strobe = 3'b100;
            2'd1:    size_strobe = 3'b010;
            2'd2:    size_strobe = 3'b001;
            default: size_strobe = 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
        case (size)
            2'd0:    extend = {{24{~uns & raw[7]}}, raw[7:0]};
            2'd1:    extend = {{16{~uns & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign accept_s   = bus.req_valid && (state_r == ST_IDLE);
    assign rsp_done_s = (state_r == ST_RESP) && bus.rsp_ready;
    assign fault_s    = fault_code(bus.req_addr, bus.req_size, bus.req_we);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; faulted requests skip the access cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (fault_s != 2'd0) ? ST_RESP : ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: next_state_s = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // ROM hands back the full word, so only ROM loads need the lane shift here.
    always_comb begin
        load_raw_s = bus.mem_data_out;
        if (rom_r) begin
            load_raw_s = bus.mem_data_out >> {off_r, 3'b000};
        end else begin
            load_raw_s = bus.mem_data_out;
        end
        load_ext_s = extend(load_raw_s, size_r, uns_r);
    end

    // Request attributes captured at the handshake for the access and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            uns_r  <= 1'b0;
            rom_r  <= 1'b0;
            size_r <= 2'd0;
            off_r  <= 2'd0;
        end else if (accept_s) begin
            we_r   <= bus.req_we;
            uns_r  <= bus.req_unsigned;
            rom_r  <= (bus.req_addr[31:28] == REGION_ROM);
            size_r <= bus.req_size;
            off_r  <= bus.req_addr[1:0];
        end
    end

    // Memory drive: non-zero only during the single access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r    <= 32'h0000_0000;
            mem_data_in_r <= 32'h0000_0000;
            mem_we_r      <= 3'b000;
        end else if (accept_s && (fault_s == 2'd0)) begin
            mem_addr_r    <= bus.req_addr;
            mem_data_in_r <= bus.req_wdata;
            mem_we_r      <= bus.req_we ? size_strobe(bus.req_size) : 3'b000;
        end else begin
            mem_addr_r    <= 32'h0000_0000;
            mem_data_in_r <= 32'h0000_0000;
            mem_we_r      <= 3'b000;
        end
    end

    // Response register: held stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 2'd0;
        end else if (accept_s && (fault_s != 2'd0)) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= fault_s;
        end else if (state_r == ST_ACCESS) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= we_r ? 32'h0000_0000 : load_ext_s;
            rsp_err_r   <= 2'd0;
        end else if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

`ifdef LSU_STATS_EN
    logic [31:0] loads_r;
    logic [31:0] stores_r;
    logic [31:0] faults_r;

    // Counters advance at the response handshake and wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loads_r  <= 32'h0000_0000;
            stores_r <= 32'h0000_0000;
            faults_r <= 32'h0000_0000;
        end else if (rsp_done_s) begin
            if (rsp_err_r != 2'd0) begin
                faults_r <= faults_r + 32'd1;
            end else if (we_r) begin
                stores_r <= stores_r + 32'd1;
            end else begin
                loads_r <= loads_r + 32'd1;
            end
        end
    end

    assign stat_loads  = loads_r;
    assign stat_stores = stores_r;
    assign stat_faults = faults_r;
`else
    assign stat_loads  = 32'h0000_0000;
    assign stat_stores = 32'h0000_0000;
    assign stat_faults = 32'h0000_0000;
`endif

    assign bus.req_ready        = (state_r == ST_IDLE);
    assign bus.rsp_valid        = rsp_valid_r;
    assign bus.rsp_rdata        = rsp_rdata_r;
    assign bus.rsp_err          = rsp_err_r;
    assign bus.mem_addr         = mem_addr_r;
    assign bus.mem_write_enable = mem_we_r;
    assign bus.mem_data_in      = mem_data_in_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small ROM/RAM/IO memory model behind it.
module tb_load_store_unit;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_we;
    } vec_t;

    localparam int NVEC = 22;

    logic        clk;
    logic        rst_n;
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_faults;
    int          checks;
    int          failures;
    int          exp_loads;
    int          exp_stores;
    int          exp_faults;

    logic [7:0]  ram_mem [0:255];
    logic [31:0] rom_mem [0:63];
    logic [31:0] io_word;
    logic [7:0]  rd_base;
    logic [31:0] rd_word;

    vec_t vecs [NVEC];

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_faults (stat_faults)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read: RAM and IO shift by the byte offset, ROM returns the whole word.
    always_comb begin
        rd_base = {bus.mem_addr[7:2], 2'b00};
        rd_word = {ram_mem[rd_base + 8'd3], ram_mem[rd_base + 8'd2],
                   ram_mem[rd_base + 8'd1], ram_mem[rd_base]};
        if (bus.mem_addr[31:28] == 4'h0) begin
            bus.mem_data_out = rom_mem[bus.mem_addr[7:2]];
        end else if (bus.mem_addr[31:28] == 4'h1) begin
            bus.mem_data_out = rd_word >> {bus.mem_addr[1:0], 3'b000};
        end else if (bus.mem_addr[31:29] == 3'b001) begin
            bus.mem_data_out = io_word >> {bus.mem_addr[1:0], 3'b000};
        end else begin
            bus.mem_data_out = 32'h0000_0000;
        end
    end

    // Memory write at the closing edge; a stray ROM write corrupts the model so it shows up.
    always @(posedge clk) begin
        logic [7:0] a;
        a = bus.mem_addr[7:0];
        if (bus.mem_write_enable != 3'b000) begin
            if (bus.mem_addr[31:28] == 4'h0) begin
                rom_mem[a[7:2]] <= bus.mem_data_in;
            end else if (bus.mem_addr[31:28] == 4'h1) begin
                if (bus.mem_write_enable[2]) begin
                    ram_mem[a] <= bus.mem_data_in[7:0];
                end
                if (bus.mem_write_enable[1]) begin
                    ram_mem[a]        <= bus.mem_data_in[7:0];
                    ram_mem[a + 8'd1] <= bus.mem_data_in[15:8];
                end
                if (bus.mem_write_enable[0]) begin
                    ram_mem[a]        <= bus.mem_data_in[7:0];
                    ram_mem[a + 8'd1] <= bus.mem_data_in[15:8];
                    ram_mem[a + 8'd2] <= bus.mem_data_in[23:16];
                    ram_mem[a + 8'd3] <= bus.mem_data_in[31:24];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0000_0000);
        chk({tag, "_rsp_err"}, {30'd0, bus.rsp_err}, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0000_0000);
        chk({tag, "_mem_we"}, {29'd0, bus.mem_write_enable}, 32'd0);
        chk({tag, "_mem_data_in"}, bus.mem_data_in, 32'h0000_0000);
        chk({tag, "_stats"}, stat_loads | stat_stores | stat_faults, 32'h0000_0000);
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int lat;
        int waitc;
        @(negedge clk);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b1;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk({tag, "_mem_we"}, {29'd0, bus.mem_write_enable}, {29'd0, v.exp_we});
        if (v.exp_we != 3'b000) begin
            chk({tag, "_mem_addr"}, bus.mem_addr, v.addr);
            chk({tag, "_mem_data_in"}, bus.mem_data_in, v.wdata);
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, (v.exp_err != 2'd0) ? 32'd1 : 32'd2);
        chk({tag, "_mem_we_after"}, {29'd0, bus.mem_write_enable}, 32'd0);
        chk({tag, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
        chk({tag, "_err"}, {30'd0, bus.rsp_err}, {30'd0, v.exp_err});
        @(posedge clk);
        #1;
        chk({tag, "_rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
        if (v.exp_err != 2'd0) begin
            exp_faults++;
        end else if (v.we) begin
            exp_stores++;
        end else begin
            exp_loads++;
        end
    endtask

    initial begin
        vec_t hv;
        checks     = 0;
        failures   = 0;
        exp_loads  = 0;
        exp_stores = 0;
        exp_faults = 0;
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h0000_0000;
        rom_mem[0] = 32'h1122_3344;
        rom_mem[1] = 32'hCAFE_F00D;
        io_word    = 32'h8001_1234;

        //             we    size  uns   addr           wdata          err   rdata          we-strobe
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 2'd0, 32'h0000_0000, 3'b001};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0000_0000, 2'd0, 32'hDEAD_BEEF, 3'b000};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h1000_0013, 32'h0000_0080, 2'd0, 32'h0000_0000, 3'b100};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h1000_0013, 32'h0000_0000, 2'd0, 32'hFFFF_FF80, 3'b000};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h1000_0013, 32'h0000_0000, 2'd0, 32'h0000_0080, 3'b000};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0000_0000, 2'd0, 32'h80AD_BEEF, 3'b000};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h1000_0012, 32'h0000_0000, 2'd0, 32'hFFFF_80AD, 3'b000};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h1000_0001, 32'h0000_0000, 2'd1, 32'h0000_0000, 3'b000};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h5000_0000, 32'h0000_0000, 2'd2, 32'h0000_0000, 3'b000};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h0BAD_F00D, 2'd3, 32'h0000_0000, 3'b000};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0000_0000, 2'd0, 32'hCAFE_F00D, 3'b000};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0000_0000, 2'd0, 32'h0000_0022, 3'b000};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0000_0000, 2'd0, 32'h0000_0011, 3'b000};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h2000_0002, 32'h0000_0000, 2'd0, 32'hFFFF_8001, 3'b000};
        vecs[14] = '{1'b0, 2'd1, 1'b1, 32'h2000_0002, 32'h0000_0000, 2'd0, 32'h0000_8001, 3'b000};
        vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h1000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000, 3'b000};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h5000_0001, 32'h0000_0000, 2'd1, 32'h0000_0000, 3'b000};
        vecs[17] = '{1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'h1234_5678, 2'd1, 32'h0000_0000, 3'b000};
        vecs[18] = '{1'b1, 2'd1, 1'b0, 32'h1000_0014, 32'h0001_7FFF, 2'd0, 32'h0000_0000, 3'b010};
        vecs[19] = '{1'b0, 2'd1, 1'b0, 32'h1000_0014, 32'h0000_0000, 2'd0, 32'h0000_7FFF, 3'b000};
        vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'h0000_0000, 2'd0, 32'h8001_1234, 3'b000};
        vecs[21] = '{1'b0, 2'd0, 1'b0, 32'h1000_0011, 32'h0000_0000, 2'd0, 32'hFFFF_FFBE, 3'b000};

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0000_0000;
        bus.req_wdata    = 32'h0000_0000;
        bus.rsp_ready    = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        // Response held for 5 cycles while a store waits on req_valid; nothing must move.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h1000_0010; bus.req_wdata = 32'h0000_0000;
        bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.req_we = 1'b1; bus.req_wdata = 32'h5555_AAAA; bus.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
            chk($sformatf("hold%0d_rdata", c), bus.rsp_rdata, 32'h80AD_BEEF);
            chk($sformatf("hold%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
            chk($sformatf("hold%0d_mem_we", c), {29'd0, bus.mem_write_enable}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("hold_release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        exp_loads++;
        hv = '{1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0000_0000, 2'd0, 32'h80AD_BEEF, 3'b000};
        do_req(hv, "hold_after");

        // Reset during the access cycle: strobe drops at once and the store never lands.
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h1000_0020; bus.req_wdata = 32'h1234_5678;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("midrst_strobe_on", {29'd0, bus.mem_write_enable}, 32'd1);
        #2;
        rst_n = 1'b0;
        exp_loads  = 0;
        exp_stores = 0;
        exp_faults = 0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        hv = '{1'b0, 2'd2, 1'b0, 32'h1000_0020, 32'h0000_0000, 2'd0, 32'h0000_0000, 3'b000};
        do_req(hv, "midrst_after");
        hv = '{1'b0, 2'd1, 1'b0, 32'h1000_0003, 32'h0000_0000, 2'd1, 32'h0000_0000, 3'b000};
        do_req(hv, "midrst_fault");

`ifdef LSU_STATS_EN
        chk("stat_loads", stat_loads, exp_loads);
        chk("stat_stores", stat_stores, exp_stores);
        chk("stat_faults", stat_faults, exp_faults);
`else
        chk("stat_loads", stat_loads, 32'h0000_0000);
        chk("stat_stores", stat_stores, 32'h0000_0000);
        chk("stat_faults", stat_faults, 32'h0000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
